// File: rtl/bin_erode_3x3.sv
// bin_erode_3x3
//   Binarizes an 8-bit luma stream against a per-frame threshold.
//   Then applies a 3x3 erosion, an AND over a 3x3 window, to remove speckle
//   and 1-pixel bridges before connected-component labelling.
//   The output is a 255/0 stream in the same vsync/href format, delayed by
//   exactly 3 clocks.
//
//   The window covers input rows k-2..k and cols j-2..j.
//   As a result the eroded image is shifted by +1 row and +1 col.
//   Output rows 0-1 and cols 0-1 are always 0.
//
// Ports
//   clk              pixel clock
//   rst              asynchronous active-high reset
//   bin_thresh[7:0]  threshold, sampled at each per_frame_vsync rising edge
//   per_frame_vsync  frame valid (high for the whole frame)
//   per_frame_href   line valid, one pixel per cycle while high
//   per_img_Y[7:0]   luma pixel
//   post_frame_vsync per_frame_vsync delayed by 3 clocks
//   post_frame_href  per_frame_href delayed by 3 clocks (low outside a frame)
//   post_img_Y[7:0]  8'd255 for foreground, 8'd0 otherwise
//
// Optional build macro BIN_ERODE_FGCOUNT_EN adds:
//   fg_count         number of 255 output pixels in the current frame
//   fg_count_valid   1-cycle pulse on the post_frame_vsync falling edge
module bin_erode_3x3 #(
  parameter int IMG_HDISP  = 450,
  parameter int IMG_VDISP  = 280,
  parameter int DEF_THRESH = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bin_thresh,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic [7:0] per_img_Y,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic [7:0] post_img_Y
`ifdef BIN_ERODE_FGCOUNT_EN
  ,
  output logic [$clog2(IMG_HDISP*IMG_VDISP+1)-1:0] fg_count,
  output logic                                     fg_count_valid
`endif
);

  localparam int CW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int RW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_HDISP - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_VDISP - 1);

  // ---------------- frame / line control ----------------
  logic          vsync_prev;
  logic          frame_active;
  logic [7:0]    thr_reg;
  logic [CW-1:0] col_cnt;
  logic          col_ovf;      // pixels beyond IMG_HDISP on this line
  logic [RW-1:0] row_cnt;
  logic          href_prev;

  logic vsync_rise;
  logic pix_en;
  logic wr_en;
  logic b;

  assign vsync_rise = per_frame_vsync & ~vsync_prev;
  assign pix_en     = per_frame_vsync & per_frame_href & frame_active;
  assign wr_en      = pix_en & ~col_ovf;
  assign b          = (per_img_Y >= thr_reg);

  // vsync_prev resets high.
  // A reset released in the middle of a frame (vsync already high) must not
  // look like a frame start. Output resumes only at a genuine rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev   <= 1'b1;
      frame_active <= 1'b0;
      thr_reg      <= DEF_THRESH[7:0];
      col_cnt      <= '0;
      col_ovf      <= 1'b0;
      row_cnt      <= '0;
      href_prev    <= 1'b0;
    end else begin
      vsync_prev <= per_frame_vsync;
      href_prev  <= pix_en;
      if (vsync_rise) begin
        thr_reg      <= bin_thresh;
        row_cnt      <= '0;
        col_cnt      <= '0;
        col_ovf      <= 1'b0;
        frame_active <= 1'b1;
      end else begin
        if (!per_frame_vsync) begin
          frame_active <= 1'b0;
        end
        if (pix_en) begin
          if (col_cnt == COL_LAST) begin
            col_ovf <= 1'b1;
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end else if (href_prev) begin
          // line just ended
          col_cnt <= '0;
          col_ovf <= 1'b0;
          if (row_cnt != ROW_LAST) begin
            row_cnt <= row_cnt + RW'(1);
          end
        end
      end
    end
  end

  // ---------------- stage 1: binarize + line buffer read ----------------
  logic          s1_href;
  logic          s1_b;
  logic          s1_wr;
  logic [CW-1:0] s1_col;
  logic          s1_ok1;       // row r-1 exists
  logic          s1_ok2;       // row r-2 exists
  logic          vs_d1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_href <= 1'b0;
      s1_b    <= 1'b0;
      s1_wr   <= 1'b0;
      s1_col  <= '0;
      s1_ok1  <= 1'b0;
      s1_ok2  <= 1'b0;
      vs_d1   <= 1'b0;
    end else begin
      vs_d1   <= per_frame_vsync;
      s1_href <= pix_en;
      s1_b    <= b & ~col_ovf;   // overflow pixels erode to 0
      s1_wr   <= wr_en;
      s1_col  <= col_cnt;
      s1_ok1  <= (row_cnt != '0);
      s1_ok2  <= (row_cnt > RW'(1));
    end
  end

  // Line buffers have a registered, read-before-write port.
  // lb1 holds row r-1 and is overwritten with the current row.
  // lb2 is written one stage later with the old lb1 value, so it holds row r-2.
  logic lb1 [IMG_HDISP];
  logic lb2 [IMG_HDISP];
  logic lb1_rd;
  logic lb2_rd;

  always_ff @(posedge clk) begin
    if (pix_en) begin
      lb1_rd <= lb1[col_cnt];
      lb2_rd <= lb2[col_cnt];
    end
    if (wr_en) begin
      lb1[col_cnt] <= b;
    end
    if (s1_wr) begin
      lb2[s1_col] <= lb1_rd;
    end
  end

  // ---------------- stage 2: 3x3 window ----------------
  logic       row_in [3];
  logic [2:0] win    [3];      // bit 0 = newest column
  logic       s2_href;
  logic       vs_d2;
  logic       win_all;

  // Rows that lie above the image count as 0.
  // Line-buffer contents left over from earlier frames are never used.
  assign row_in[0] = s1_b;
  assign row_in[1] = lb1_rd & s1_ok1;
  assign row_in[2] = lb2_rd & s1_ok2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_href <= 1'b0;
      vs_d2   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        win[i] <= '0;
      end
    end else begin
      s2_href <= s1_href;
      vs_d2   <= vs_d1;
      if (s1_href) begin
        for (int i = 0; i < 3; i++) begin
          // The first pixel of a line starts from an empty window.
          // Columns -1 and -2 therefore read as 0.
          win[i] <= s2_href ? {win[i][1:0], row_in[i]} : {2'b00, row_in[i]};
        end
      end
    end
  end

  assign win_all = (&win[0]) & (&win[1]) & (&win[2]);

  // ---------------- stage 3: output ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_img_Y       <= 8'd0;
    end else begin
      post_frame_vsync <= vs_d2;
      post_frame_href  <= s2_href;
      post_img_Y       <= (s2_href && win_all) ? 8'd255 : 8'd0;
    end
  end

`ifdef BIN_ERODE_FGCOUNT_EN
  localparam int FGW = $clog2(IMG_HDISP*IMG_VDISP+1);

  // Counts in step with the output.
  // The count clears as post_frame_vsync rises and is published as it falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fg_count       <= '0;
      fg_count_valid <= 1'b0;
    end else begin
      fg_count_valid <= post_frame_vsync & ~vs_d2;
      if (vs_d2 && !post_frame_vsync) begin
        fg_count <= '0;
      end else if (s2_href && win_all) begin
        fg_count <= fg_count + FGW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bin_erode_3x3.sv
// Testbench for bin_erode_3x3.
// It uses a reduced image size (20x12) so that many frames fit in a short run.
// The reference model stores each frame's binary image in an array and
// computes every output pixel directly from the 3x3 AND definition.
// Expected stream values go through a 3-cycle history.
// A per-cycle compare process checks vsync, href and pixel against that
// history. Literal expectations pin per-frame totals and positions.
module tb_bin_erode_3x3;
  localparam int H   = 20;
  localparam int V   = 12;
  localparam int FGW = $clog2(H*V+1);
  localparam int INT = (H-2)*(V-2);   // interior pixel count = 180

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bin_thresh = 8'd0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] y = 8'd0;
  logic       post_vsync;
  logic       post_href;
  logic [7:0] post_y;
`ifdef BIN_ERODE_FGCOUNT_EN
  logic [FGW-1:0] fg_count;
  logic           fg_count_valid;
`endif

  always #5 clk = ~clk;

  bin_erode_3x3 #(.IMG_HDISP(H), .IMG_VDISP(V), .DEF_THRESH(128)) dut (
    .clk(clk),
    .rst(rst),
    .bin_thresh(bin_thresh),
    .per_frame_vsync(vsync),
    .per_frame_href(href),
    .per_img_Y(y),
    .post_frame_vsync(post_vsync),
    .post_frame_href(post_href),
    .post_img_Y(post_y)
`ifdef BIN_ERODE_FGCOUNT_EN
    ,
    .fg_count(fg_count),
    .fg_count_valid(fg_count_valid)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // model state
  bit         model_active = 0;
  int         frame_thr = 128;
  bit         img [V][H+4];
  logic [9:0] cur_exp = '0;
  logic [9:0] h1 = '0, h2 = '0, h3 = '0;
  int         mod_fg = 0;
  bit         mh_prev_vs = 0;

  // observed per-frame stats (DUT side)
  int ncyc = 0;
  int obs_cnt = 0, obs_hr = 0, orow = 0, ocol = 0, last_r = -1, last_c = -1;
  int frame_obs = 0, frame_obs_hr = 0;
  int t_in = 0, t_out = 0;
  bit got_in = 0, got_out = 0, pv_prev = 0, ph_prev = 0, iv_prev = 0;
  int last_fg = -1;

  task automatic pin(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit exp_out(input int r, input int c);
    if (r < 2 || c < 2 || c >= H) return 1'b0;
    for (int a = 0; a < 3; a++)
      for (int bb = 0; bb < 3; bb++)
        if (!img[r-a][c-bb]) return 1'b0;
    return 1'b1;
  endfunction

  // per-cycle compare process
  always @(negedge clk) begin
    logic [9:0] act;
    ncyc++;
    if (rst) begin
      h1 = '0; h2 = '0; h3 = '0;
      mod_fg = 0; mh_prev_vs = 0;
    end
    act = {post_vsync, post_href, post_y};
    n_vec++;
    if (act !== h3) begin
      n_bad++;
      $display("FAIL stream cyc=%0d got vs=%0b href=%0b y=%0d expected vs=%0b href=%0b y=%0d",
               ncyc, act[9], act[8], act[7:0], h3[9], h3[8], h3[7:0]);
    end
    if (h3[9] && !mh_prev_vs) mod_fg = 0;
    if (h3[8] && h3[7:0] == 8'd255) mod_fg++;
    mh_prev_vs = h3[9];
`ifdef BIN_ERODE_FGCOUNT_EN
    if (fg_count_valid) begin
      n_vec++;
      if (fg_count !== FGW'(mod_fg)) begin
        n_bad++;
        $display("FAIL fg_count got %0d expected %0d", fg_count, mod_fg);
      end
      last_fg = int'(fg_count);
    end
`endif
    // DUT-side statistics
    if (post_vsync && !pv_prev) begin
      obs_cnt = 0; obs_hr = 0; orow = 0; ocol = 0; got_out = 0;
    end
    if (post_href) begin
      obs_hr++;
      if (post_y == 8'd255) begin obs_cnt++; last_r = orow; last_c = ocol; end
      if (!got_out) begin t_out = ncyc; got_out = 1; end
      ocol++;
    end else if (ph_prev) begin
      orow++; ocol = 0;
    end
    if (!post_vsync && pv_prev) begin frame_obs = obs_cnt; frame_obs_hr = obs_hr; end
    pv_prev = post_vsync;
    ph_prev = post_href;
    if (vsync && !iv_prev) got_in = 0;
    if (vsync && href && !got_in) begin t_in = ncyc; got_in = 1; end
    iv_prev = vsync;
    if (!rst) begin h3 = h2; h2 = h1; h1 = cur_exp; end
  end

  task automatic step(input bit vs, input bit hr, input logic [7:0] yy,
                      input bit r, input bit eh, input bit ey);
    @(posedge clk); #1;
    rst = r; vsync = vs; href = hr; y = yy;
    cur_exp = {vs, eh, (ey ? 8'd255 : 8'd0)};
  endtask

  localparam int K_255 = 0, K_0 = 1, K_DOT = 2, K_BLK = 3, K_150 = 4, K_RND = 5, K_PAT = 6;

  function automatic logic [7:0] pix(input int kind, input int r, input int c);
    case (kind)
      K_255:   return 8'd255;
      K_0:     return 8'd0;
      K_DOT:   return (r == 5 && c == 8) ? 8'd255 : 8'd0;
      K_BLK:   return (r >= 4 && r <= 6 && c >= 7 && c <= 9) ? 8'd255 : 8'd0;
      K_150:   return 8'd150;
      K_RND:   return 8'($urandom_range(0, 255));
      default: return (((r*7 + c*13) % 5) != 0) ? 8'd255 : 8'd0;
    endcase
  endfunction

  task automatic frame(input int kind, input int thr, input int extra,
                       input int rst_row, input int mid_thr);
    logic [7:0] yy;
    bit rr, ey;
    bin_thresh = 8'(thr);
    frame_thr = thr;
    model_active = 1;
    repeat (3) step(1, 0, 8'd0, 0, 0, 0);
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H + extra; c++) begin
        yy = pix(kind, r, c);
        img[r][c] = (int'(yy) >= frame_thr);
        rr = (r == rst_row) && (c == 3 || c == 4);
        if (rr) model_active = 0;
        ey = model_active && exp_out(r, c);
        step(1, 1, yy, rr, model_active, ey);
        if (r == V/2 && c == 0 && mid_thr >= 0) bin_thresh = 8'(mid_thr);
      end
      repeat ($urandom_range(1, 4)) step(1, 0, 8'd0, 0, 0, 0);
    end
    step(1, 0, 8'd0, 0, 0, 0);
    model_active = 0;
    repeat (200) step(0, 0, 8'd0, 0, 0, 0);
  endtask

  initial begin
    int ref_cnt;
    repeat (3) @(negedge clk);
    pin("rst_post_vsync", int'(post_vsync), 0);
    pin("rst_post_href", int'(post_href), 0);
    pin("rst_post_y", int'(post_y), 0);
`ifdef BIN_ERODE_FGCOUNT_EN
    pin("rst_fg_count", int'(fg_count), 0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) step(0, 0, 8'd0, 0, 0, 0);

    // 1: all 255
    frame(K_255, 128, 0, -1, -1);
    pin("s1_fg_pixels", frame_obs, INT);
    pin("s1_href_latency", t_out - t_in, 3);
    pin("s1_href_count", frame_obs_hr, H*V);
`ifdef BIN_ERODE_FGCOUNT_EN
    pin("s1_fg_count", last_fg, INT);
`endif
    // 2: all 0 with threshold 0
    frame(K_0, 0, 0, -1, -1);
    pin("s2_fg_pixels", frame_obs, INT);
    // 3: isolated dot, then 3x3 block
    frame(K_DOT, 128, 0, -1, -1);
    pin("s3_dot_pixels", frame_obs, 0);
    frame(K_BLK, 128, 0, -1, -1);
    pin("s3_blk_pixels", frame_obs, 1);
    pin("s3_blk_row", last_r, 6);
    pin("s3_blk_col", last_c, 9);
`ifdef BIN_ERODE_FGCOUNT_EN
    pin("s3_fg_count", last_fg, 1);
`endif
    // 4: threshold change mid-frame takes effect next frame
    frame(K_150, 128, 0, -1, 200);
    pin("s4_old_thr", frame_obs, INT);
    frame(K_150, 200, 0, -1, -1);
    pin("s4_new_thr", frame_obs, 0);
    // 5: reset mid-frame
    frame(K_255, 128, 0, 5, -1);
    pin("s5_no_href_after_rst", frame_obs_hr, 0);
    frame(K_255, 128, 0, -1, -1);
    pin("s5_next_frame", frame_obs, INT);
    // 6: twelve identical frames, some with extra pixels per line
    ref_cnt = -1;
    for (int f = 0; f < 12; f++) begin
      frame(K_PAT, 128, (f % 4 == 3) ? 2 : 0, -1, -1);
      if (f == 0) ref_cnt = frame_obs;
      else pin("s6_repeat", frame_obs, ref_cnt);
    end
    // random frames against the model
    for (int f = 0; f < 6; f++) begin
      frame(K_RND, $urandom_range(20, 70), $urandom_range(0, 2), -1,
            $urandom_range(0, 255));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
